// File: rtl/rr_arbiter4_enc.sv
// rr_arbiter4_enc
//   Round-robin arbiter sharing one 4-to-2 encoded resource between 4
//   requesters. Grants are registered one-hot with a matching 2-bit index.
//   A hold-timeout lets a waiting requester preempt a long-running owner.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   req[3:0]   level-sensitive requests, bit i = requester i
//   gnt[3:0]   one-hot grant, zero when idle
//   gnt_idx    encoded index of gnt (2'b00 when no grant)
//   gnt_valid  |gnt
//   preempt    one-cycle pulse when a grant moved because of the hold timeout
module rr_arbiter4_enc #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Last hold value before a waiting requester may take over.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

    state_t           state, state_n;
    logic [3:0]       gnt_n;
    logic [1:0]       idx_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             pre_n;

    logic [3:0]       others;
    logic [3:0]       srch_req;
    logic [1:0]       srch_base;
    logic [1:0]       winner;

    // First set bit scanning base, base+1, ... (mod 4). Scanning the offsets
    // from far to near lets the nearest hit overwrite the others.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] i;
        pick = base;
        for (int k = 3; k >= 0; k--) begin
            i = base + 2'(k);
            if (r[i]) pick = i;
        end
    endfunction

    assign others    = req & ~gnt;
    // From IDLE search from ptr; while granted, the next owner is searched
    // from the slot after the current owner, excluding the owner itself.
    assign srch_req  = (state == IDLE) ? req : others;
    assign srch_base = (state == IDLE) ? ptr : gnt_idx + 2'd1;
    assign winner    = pick(srch_req, srch_base);
    assign gnt_valid = |gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            preempt  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_idx  <= idx_n;
            preempt  <= pre_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        pre_n   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_n   = 4'b0001 << winner;
                    idx_n   = winner;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    // Release wins over timeout, so no preempt pulse here.
                    ptr_n = gnt_idx + 2'd1;
                    if (|others) begin
                        gnt_n  = 4'b0001 << winner;
                        idx_n  = winner;
                        hold_n = '0;
                    end else begin
                        gnt_n   = '0;
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && |others) begin
                    ptr_n  = gnt_idx + 2'd1;
                    gnt_n  = 4'b0001 << winner;
                    idx_n  = winner;
                    hold_n = '0;
                    pre_n  = 1'b1;
                end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) begin
                    // Saturating: a lone owner parks at HOLD_LAST so the first
                    // competing request afterwards preempts immediately.
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter4_enc.sv
module tb_rr_arbiter4_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [3:0] gnt;
        logic       pre;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter4_enc #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        enc = 2'b00;
        for (int k = 0; k < 4; k++) if (g[k]) enc = 2'(k);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Monitor: every edge that has a pending expectation is checked just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".gnt"},   gnt,                e.gnt);
            chk({e.tag, ".idx"},   {2'b00, gnt_idx},   {2'b00, enc(e.gnt)});
            chk({e.tag, ".valid"}, {3'b000, gnt_valid}, {3'b000, |e.gnt});
            chk({e.tag, ".pre"},   {3'b000, preempt},  {3'b000, e.pre});
        end
    end

    // Drive req on the falling edge; expectation applies after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] eg, input logic ep);
        exp_t e;
        @(negedge clk);
        req = r;
        e.gnt = eg;
        e.pre = ep;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"},   gnt,                 4'b0000);
        chk({tag, ".idx"},   {2'b00, gnt_idx},    4'b0000);
        chk({tag, ".valid"}, {3'b000, gnt_valid}, 4'b0000);
        chk({tag, ".pre"},   {3'b000, preempt},   4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset acts before any clock edge
        req = 4'b1111;
        #1 rst = 1'b1;
        #1 chk_zero("t1_async");
        @(posedge clk); #1 chk_zero("t1_edge");
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;

        // T3: rotation 0,1,2,3,0 with no idle bubble
        cyc("t3_g0", 4'b1111, 4'b0001, 1'b0);
        cyc("t3_g1", 4'b1110, 4'b0010, 1'b0);
        cyc("t3_g2", 4'b1101, 4'b0100, 1'b0);
        cyc("t3_g3", 4'b1011, 4'b1000, 1'b0);
        cyc("t3_g0b", 4'b0111, 4'b0001, 1'b0);
        cyc("t3_idle", 4'b0000, 4'b0000, 1'b0);   // ptr -> 1

        // T2: single requester
        cyc("t2_gnt", 4'b0100, 4'b0100, 1'b0);
        cyc("t2_rel", 4'b0000, 4'b0000, 1'b0);    // ptr -> 3

        // T4: wrap from ptr 3 goes to 0, not 2
        cyc("t4_wrap", 4'b0101, 4'b0001, 1'b0);
        cyc("t4_rel", 4'b0000, 4'b0000, 1'b0);    // ptr -> 1
        cyc("t5_set3", 4'b1000, 4'b1000, 1'b0);
        cyc("t5_set0", 4'b0000, 4'b0000, 1'b0);   // ptr -> 0

        // T5: owner 0 held exactly 8 cycles, then preempted by 1
        for (int k = 0; k < 8; k++) cyc($sformatf("t5_hold%0d", k), 4'b0011, 4'b0001, 1'b0);
        cyc("t5_preempt", 4'b0011, 4'b0010, 1'b1);
        cyc("t5_after", 4'b0011, 4'b0010, 1'b0);
        cyc("t5_rel", 4'b0000, 4'b0000, 1'b0);

        // Lone requester keeps the grant; first competitor after saturation preempts
        for (int k = 0; k < 12; k++) cyc($sformatf("alone%0d", k), 4'b0001, 4'b0001, 1'b0);
        cyc("sat_preempt", 4'b0011, 4'b0010, 1'b1);

        // Release on the same edge as the timeout: release wins, no pulse
        for (int k = 0; k < 7; k++) cyc($sformatf("o1_hold%0d", k), 4'b0011, 4'b0010, 1'b0);
        cyc("rel_vs_to", 4'b0001, 4'b0001, 1'b0);
        cyc("rel_idle", 4'b0000, 4'b0000, 1'b0);

        // T6: reset mid-grant
        cyc("t6_own3", 4'b1000, 4'b1000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_zero("t6_async");
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        begin
            exp_t e;
            e.gnt = 4'b0001;
            e.pre = 1'b0;
            e.tag = "t6_ptr0";
            exp_q.push_back(e);
        end
        cyc("t6_rel", 4'b0000, 4'b0000, 1'b0);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tot++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
